// File: rtl/mem_ctrl_pkg.sv
// Shared defaults and state encoding for the data-memory copy controller.
package mem_ctrl_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } copy_state_t;
endpackage

// File: rtl/mem_copy_ctrl.sv
// Arbitrates the single-port data memory between CPU load/store traffic and a
// byte-serial block-copy engine; the CPU is stalled while a copy runs.
module mem_copy_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    input  logic              cpuReq,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuDataIn,
    input  logic              cpuWriteEnable,
    output logic              cpuStall,
    output logic [DATA_W-1:0] cpuDataOut,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memWriteEnable,
    input  logic [DATA_W-1:0] memDataOut
);

    copy_state_t       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        rem_d          = rem_q;
        byte_d         = byte_q;
        memAddr        = cpuAddr;
        memDataIn      = cpuDataIn;
        memWriteEnable = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                busy           = 1'b0;
                memWriteEnable = cpuReq & cpuWriteEnable;
                // A CPU access coinciding with start is serviced this cycle.
                if (start) begin
                    src_d   = srcAddr;
                    dst_d   = dstAddr;
                    rem_d   = len;
                    state_d = (len == '0) ? FIN : RD;
                end
            end
            RD: begin
                memAddr   = src_q;
                memDataIn = byte_q;
                byte_d    = memDataOut;
                state_d   = WR;
            end
            WR: begin
                memAddr        = dst_q;
                memDataIn      = byte_q;
                memWriteEnable = 1'b1;
                src_d          = src_q + ADDR_W'(1);
                dst_d          = dst_q + ADDR_W'(1);
                rem_d          = rem_q - ADDR_W'(1);
                state_d        = (rem_q == ADDR_W'(1)) ? FIN : RD;
            end
            FIN: begin
                memAddr   = dst_q;
                memDataIn = byte_q;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpuStall   = cpuReq & (state_q != IDLE);
    assign cpuDataOut = memDataOut;

endmodule
